// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register file's single write port.
// Each source feeds a private 2-entry FIFO; round-robin drains them into a registered write stage.
module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_reg,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_reg,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  output logic        ctrl_writeEn,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       wb_valid;
  logic [1:0]       wb_ready;
  logic [1:0]       push;
  logic [1:0]       head_valid;
  logic [1:0]       grant;
  logic [1:0][4:0]  wb_reg;
  logic [1:0][4:0]  head_reg;
  logic [1:0][31:0] wb_data;
  logic [1:0][31:0] head_data;
  logic             gnt_port;

  logic [4:0]       fifo_reg_q  [2][DEPTH];
  logic [31:0]      fifo_data_q [2][DEPTH];
  logic [DEPTH-1:0] vld_q       [2];
  logic [PW-1:0]    rd_ptr_q    [2];
  logic [PW-1:0]    wr_ptr_q    [2];
  logic             last_q;
  logic             en_q;
  logic [4:0]       wreg_q;
  logic [31:0]      wdata_q;

  assign wb_valid = {wb1_valid, wb0_valid};
  assign wb_reg   = {wb1_reg, wb0_reg};
  assign wb_data  = {wb1_data, wb0_data};
  assign wb0_ready = wb_ready[0];
  assign wb1_ready = wb_ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Ready depends on occupancy only, so a full FIFO stays closed even while it pops.
      assign wb_ready[gi]   = ~&vld_q[gi];
      assign push[gi]       = wb_valid[gi] & wb_ready[gi];
      assign head_valid[gi] = vld_q[gi][rd_ptr_q[gi]];
      assign head_reg[gi]   = fifo_reg_q[gi][rd_ptr_q[gi]];
      assign head_data[gi]  = fifo_data_q[gi][rd_ptr_q[gi]];
    end
  endgenerate

  // Same-register collision goes to port 1 (program-order older) so port 0's value lands last.
  always_comb begin
    grant = 2'b00;
    if (&head_valid) begin
      if (head_reg[0] == head_reg[1]) grant = 2'b10;
      else                            grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = head_valid;
    end
  end
  assign gnt_port = grant[1];

  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        fifo_reg_q[p][wr_ptr_q[p]]  <= wb_reg[p];
        fifo_data_q[p][wr_ptr_q[p]] <= wb_data[p];
      end
    end
    if (ctrl_reset) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p]    <= '0;
        rd_ptr_q[p] <= '0;
        wr_ptr_q[p] <= '0;
      end
      last_q  <= 1'b1;
      en_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          vld_q[p][wr_ptr_q[p]] <= 1'b1;
          wr_ptr_q[p]           <= wr_ptr_q[p] + PW'(1);
        end
        if (grant[p]) begin
          vld_q[p][rd_ptr_q[p]] <= 1'b0;
          rd_ptr_q[p]           <= rd_ptr_q[p] + PW'(1);
        end
      end
      en_q <= |grant;
      if (|grant) begin
        last_q  <= gnt_port;
        wreg_q  <= head_reg[gnt_port];
        wdata_q <= head_data[gnt_port];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[p][i]) busy[fifo_reg_q[p][i]] = 1'b1;
      end
    end
    if (en_q) busy[wreg_q] = 1'b1;
  end

  assign ctrl_writeEn  = en_q;
  assign ctrl_writeReg = wreg_q;
  assign data_writeReg = wdata_q;
endmodule
